mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory stage of the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Executes loads and stores over a req/gnt/rvalid data bus.
- Aligns store data and generates byte enables. Extracts and sign/zero-extends load data.
- Produces the writeback fields fed into the MEM/WB register.
- Asserts stall while a bus access is outstanding; the pipeline drives MEM/WB clk_en = ~stall and holds upstream registers.

Parameters:
- TIMEOUT, 255: max cycles spent in REQ+WAIT before the access is aborted with bus_err.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  instruction present in MEM stage
- mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- addr  in  32  effective address (ALU result for mem ops)
- alu_result  in  32  writeback value for non-memory ops
- store_data  in  32  rt value for stores
- rd_in  in  5  destination register
- regwrite_in  in  1  instruction writes a register
- bus_gnt  in  1  bus accepted the request
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data
- bus_req  out  1  request
- bus_we  out  1  write
- bus_addr  out  32  word-aligned address
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- stall  out  1  hold pipeline
- wb_regwrite  out  1  register write enable to MEM/WB
- wb_rd  out  5  destination to MEM/WB
- wb_data  out  32  writeback data to MEM/WB
- exc_adel  out  1  misaligned load
- exc_ades  out  1  misaligned store
- bus_err  out  1  access timed out

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE, counter = 0, captured data = 0. All outputs 0 while in IDLE with in_valid = 0.
- Upstream holds all inputs stable while stall = 1 and through the DONE cycle.
- IDLE, no memory op (in_valid = 0, or op NONE/illegal):
  - Combinational pass-through: wb_data = alu_result, wb_rd = rd_in, wb_regwrite = in_valid & regwrite_in.
  - stall = 0, no bus activity.
- IDLE, memory op present:
  - Alignment: LH/LHU/SH require addr[0] = 0; LW/SW require addr[1:0] = 0.
  - Misaligned: exc_adel (loads) or exc_ades (stores) = 1 in the same cycle. No request issued, stall = 0, wb_regwrite = 0, stay in IDLE.
  - Aligned: stall = 1, go to REQ next cycle.
- REQ:
  - bus_req = 1, stall = 1.
  - bus_addr = {addr[31:2], 2'b00}; bus_we = 1 for stores, 0 for loads.
  - bus_be: loads 1111; SW 1111; SH 0011 << addr[1:0]; SB 0001 << addr[1:0].
  - bus_wdata: SB {4{store_data[7:0]}}; SH {2{store_data[15:0]}}; SW store_data.
  - Bus outputs are held stable until gnt.
  - On bus_gnt: store → DONE; load → WAIT.
- WAIT:
  - stall = 1, bus_req = 0.
  - bus_rvalid is sampled only in WAIT; rvalid seen in REQ is ignored.
  - On bus_rvalid, capture the extracted value and go to DONE:
    - sel = bus_rdata >> (8 × addr[1:0]).
    - LB sign-extends sel[7:0]; LBU zero-extends it.
    - LH sign-extends sel[15:0]; LHU zero-extends it.
    - LW takes bus_rdata unchanged.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT with no gnt/rvalid, go to DONE with an error flag set.
  - gnt/rvalid in that same cycle takes priority over the timeout.
- DONE (exactly one cycle):
  - stall = 0, bus_req = 0.
  - wb_rd = rd_in.
  - wb_data = captured value for loads, 0 for stores.
  - wb_regwrite = regwrite_in & is_load & ~err.
  - bus_err = err.
  - Next state IDLE; error flag clears.
- Reset mid-access: at the reset edge, go to IDLE and drop bus_req. Any later gnt/rvalid belonging to the aborted access is ignored in IDLE.
- Request to DONE latency: stores 2 + gnt wait cycles; loads 3 + gnt wait + rvalid wait cycles.

Test Plan:
- ADD pass-through: in_valid = 1, op = 0, alu_result = 0x1234, rd = 5, regwrite = 1 → same cycle: wb_data = 0x1234, wb_rd = 5, wb_regwrite = 1, stall = 0, bus_req = 0.
- LB, addr = 0x1003, immediate gnt, rvalid 1 cycle later with rdata = 0x80FF_0000 → stall high 3 cycles; DONE: wb_data = 0xFFFF_FF80, wb_regwrite = 1. LBU on the same data → 0x0000_0080.
- SH, addr = 0x2002, store_data = 0xABCD1234, gnt after 2 cycles → bus_addr = 0x2000, be = 1100, wdata = 0x12341234, we = 1; stall = 1 for 4 cycles total; DONE: wb_regwrite = 0.
- LW, addr = 0x3001 → exc_adel = 1 same cycle, stall = 0, bus_req never asserted, wb_regwrite = 0. SW, addr = 0x3002 → exc_ades = 1.
- LW with gnt never asserted, TIMEOUT = 4 → bus_req high 4 cycles, then DONE: bus_err = 1, wb_regwrite = 0; next cycle IDLE.
- LW in WAIT, reset pulse for 1 cycle → next cycle IDLE, stall = 0. Late rvalid ignored: no wb_regwrite.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline: runs loads/stores over a req/gnt/rvalid bus,
// aligns store data, extracts load data and produces the MEM/WB writeback fields.
module mem_access_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        regwrite_in,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    output logic        stall,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      cap;
    logic             err;

    logic        is_load, is_store, misaligned, timeout_hit;
    logic [31:0] sel, load_val;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (mem_op)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1;  misaligned = addr[0];      end
            OP_LW:         begin is_load = 1'b1;  misaligned = |addr[1:0];   end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; misaligned = addr[0];      end
            OP_SW:         begin is_store = 1'b1; misaligned = |addr[1:0];   end
            default: ;
        endcase
    end

    assign sel = bus_rdata >> {addr[1:0], 3'b000};

    always_comb begin
        load_val = bus_rdata;
        case (mem_op)
            OP_LB:   load_val = {{24{sel[7]}}, sel[7:0]};
            OP_LBU:  load_val = {24'd0, sel[7:0]};
            OP_LH:   load_val = {{16{sel[15]}}, sel[15:0]};
            OP_LHU:  load_val = {16'd0, sel[15:0]};
            default: load_val = bus_rdata;
        endcase
    end

    // >= rather than == so a gnt on the last REQ cycle still leaves WAIT bounded.
    assign timeout_hit = (cnt >= CNT_LAST);
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: cnt <= '0;
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (!bus_gnt && timeout_hit) err <= 1'b1;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus_rvalid) cap <= load_val;
                    else if (timeout_hit) err <= 1'b1;
                end
                DONE: err <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_be      = '0;
        bus_wdata   = '0;
        stall       = 1'b0;
        wb_regwrite = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        exc_adel    = 1'b0;
        exc_ades    = 1'b0;
        bus_err     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && (is_load || is_store)) begin
                    if (misaligned) begin
                        exc_adel = is_load;
                        exc_ades = is_store;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = REQ;
                    end
                end else if (in_valid) begin
                    // With no instruction present every output stays at zero.
                    wb_data     = alu_result;
                    wb_rd       = rd_in;
                    wb_regwrite = regwrite_in;
                end
            end
            REQ: begin
                bus_req  = 1'b1;
                stall    = 1'b1;
                bus_addr = {addr[31:2], 2'b00};
                bus_we   = is_store;
                case (mem_op)
                    OP_SB: begin
                        bus_be    = 4'b0001 << addr[1:0];
                        bus_wdata = {4{store_data[7:0]}};
                    end
                    OP_SH: begin
                        bus_be    = 4'b0011 << addr[1:0];
                        bus_wdata = {2{store_data[15:0]}};
                    end
                    OP_SW: begin
                        bus_be    = 4'b1111;
                        bus_wdata = store_data;
                    end
                    default: bus_be = 4'b1111;
                endcase
                if (bus_gnt)          state_nxt = is_store ? DONE : WAIT;
                else if (timeout_hit) state_nxt = DONE;
            end
            WAIT: begin
                stall = 1'b1;
                if (bus_rvalid || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                wb_rd       = rd_in;
                wb_data     = is_load ? cap : 32'd0;
                wb_regwrite = regwrite_in & is_load & ~err;
                bus_err     = err;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed table of single-cycle cases, hand-written
// multi-cycle corner sequences, and randomized accesses against a timing/data model.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  mem_op;
    logic [31:0] addr, alu_result, store_data;
    logic [4:0]  rd_in;
    logic        regwrite_in;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        stall, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_adel, exc_ades, bus_err;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_op(mem_op), .addr(addr),
        .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
        .regwrite_in(regwrite_in), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .stall(stall), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_data(wb_data), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] lo,
                                               input logic [31:0] d);
        logic [31:0] s;
        s = d >> (8 * lo);
        case (op)
            4'd1:    return s[7]  ? (32'hFFFF_FF00 | {24'd0, s[7:0]})  : {24'd0, s[7:0]};
            4'd2:    return {24'd0, s[7:0]};
            4'd3:    return s[15] ? (32'hFFFF_0000 | {16'd0, s[15:0]}) : {16'd0, s[15:0]};
            4'd4:    return {16'd0, s[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd3 || op == 4'd4 || op == 4'd7) return a[0];
        if (op == 4'd5 || op == 4'd8) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    // driver tasks
    task automatic drive(input logic iv, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
        in_valid = iv; mem_op = op; addr = a; alu_result = alu;
        store_data = sd; rd_in = rd; regwrite_in = rw;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    // One IDLE cycle that must not start an access; expectations from the op rules.
    task automatic idle_cycle(input logic iv, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        bit mem, ld;
        mem = (op >= 4'd1 && op <= 4'd8);
        ld  = (op >= 4'd1 && op <= 4'd5);
        @(negedge clk);
        drive(iv, op, a, alu, 32'd0, rd, rw);
        #1;
        chk("rnd_idle_stall", 32'(stall), 32'd0);
        chk("rnd_idle_req", 32'(bus_req), 32'd0);
        chk("rnd_idle_adel", 32'(exc_adel), 32'(iv && mem && ld && model_misaligned(op, a)));
        chk("rnd_idle_ades", 32'(exc_ades), 32'(iv && mem && !ld && model_misaligned(op, a)));
        chk("rnd_idle_wbrw", 32'(wb_regwrite), 32'(iv && !mem && rw));
        chk("rnd_idle_wbdata", wb_data, (iv && !mem) ? alu : 32'd0);
    endtask

    // Full aligned access: g = cycles before gnt, r = cycles between gnt and rvalid.
    task automatic run_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                              input logic [4:0] rd, input logic rw, input int g, input int r,
                              input logic [31:0] rdata, output logic [31:0] got,
                              output int nstall);
        bit ld, st, err_exp;
        int n_acc, n_req;
        logic [31:0] exp_d, exp_wd;
        logic [3:0]  exp_be;
        ld = (op >= 4'd1 && op <= 4'd5);
        st = !ld;
        if (st) begin
            err_exp = (g + 1 > TO);
            n_acc   = err_exp ? TO : g + 1;
            n_req   = n_acc;
        end else if (g + 1 > TO) begin
            err_exp = 1'b1; n_acc = TO; n_req = TO;
        end else if (r == 0 || g + 1 + r < TO) begin
            err_exp = 1'b0; n_acc = g + 2 + r; n_req = g + 1;
        end else begin
            err_exp = 1'b1; n_acc = (g + 2 > TO) ? g + 2 : TO; n_req = g + 1;
        end
        exp_be = 4'hF;
        exp_wd = sd;
        if (op == 4'd6) begin exp_be = 4'b0001 << a[1:0]; exp_wd = {4{sd[7:0]}};  end
        if (op == 4'd7) begin exp_be = 4'b0011 << a[1:0]; exp_wd = {2{sd[15:0]}}; end
        if (ld) exp_q.push_back(model_load(op, a[1:0], rdata));

        @(negedge clk);
        drive(1'b1, op, a, 32'hDEAD_0000, sd, rd, rw);
        #1;
        chk("acc_issue_stall", 32'(stall), 32'd1);
        chk("acc_issue_req", 32'(bus_req), 32'd0);
        nstall = 1;
        for (int c = 1; c <= n_acc; c++) begin
            @(negedge clk);
            bus_gnt    = (c == g + 1);
            bus_rvalid = ld && (c == g + 2 + r);
            bus_rdata  = bus_rvalid ? rdata : $urandom;
            if (c <= g + 1 && $urandom_range(0, 3) == 0) bus_rvalid = 1'b1;
            #1;
            chk("acc_stall", 32'(stall), 32'd1);
            chk("acc_req", 32'(bus_req), 32'(c <= n_req));
            if (c <= n_req) begin
                chk("acc_addr", bus_addr, {a[31:2], 2'b00});
                chk("acc_we", 32'(bus_we), 32'(st));
                chk("acc_be", 32'(bus_be), 32'(exp_be));
                if (st) chk("acc_wdata", bus_wdata, exp_wd);
            end
            if (stall) nstall++;
        end
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(bus_req), 32'd0);
        chk("done_err", 32'(bus_err), 32'(err_exp));
        chk("done_rd", 32'(wb_rd), 32'(rd));
        chk("done_regwrite", 32'(wb_regwrite), 32'(rw && ld && !err_exp));
        exp_d = 32'd0;
        if (ld) exp_d = exp_q.pop_front();
        if (!err_exp) chk("done_data", wb_data, exp_d);
        got = wb_data;
    endtask

    typedef struct {
        logic        iv;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_adel;
        logic        e_ades;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] got;
        int          ns;

        tbl[0] = '{1'b1, 4'd0,  32'h0,    32'h1234,      5'd5,  1'b1, 32'h1234,      5'd5,  1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 4'd0,  32'h4,    32'hDEAD_BEEF, 5'd31, 1'b0, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'd0,  32'h0,    32'h55,        5'd3,  1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 4'd12, 32'h8,    32'hCAFE,      5'd7,  1'b1, 32'hCAFE,      5'd7,  1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 4'd5,  32'h3001, 32'h77,        5'd8,  1'b1, 32'h0,         5'd0,  1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 4'd8,  32'h3002, 32'h77,        5'd8,  1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 4'd3,  32'h11,   32'h77,        5'd2,  1'b1, 32'h0,         5'd0,  1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 4'd7,  32'h3,    32'h77,        5'd2,  1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 4'd5,  32'h3001, 32'h99,        5'd4,  1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 4'd15, 32'hC,    32'h0BAD_F00D, 5'd1,  1'b1, 32'h0BAD_F00D, 5'd1,  1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_wbrw", 32'(wb_regwrite), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].op, tbl[i].a, tbl[i].alu, 32'h5A5A_5A5A, tbl[i].rd, tbl[i].rw);
            #1;
            chk("tbl_wbdata", wb_data, tbl[i].e_data);
            chk("tbl_wbrd", 32'(wb_rd), 32'(tbl[i].e_rd));
            chk("tbl_wbrw", 32'(wb_regwrite), 32'(tbl[i].e_rw));
            chk("tbl_stall", 32'(stall), 32'd0);
            chk("tbl_req", 32'(bus_req), 32'd0);
            chk("tbl_adel", 32'(exc_adel), 32'(tbl[i].e_adel));
            chk("tbl_ades", 32'(exc_ades), 32'(tbl[i].e_ades));
        end

        // LB / LBU at byte 3, immediate gnt, rvalid one cycle later
        run_access(4'd1, 32'h1003, 32'd0, 5'd6, 1'b1, 0, 0, 32'h80FF_0000, got, ns);
        chk("lb_data", got, 32'hFFFF_FF80);
        chk("lb_stall_cycles", 32'(ns), 32'd3);
        run_access(4'd2, 32'h1003, 32'd0, 5'd6, 1'b1, 0, 0, 32'h80FF_0000, got, ns);
        chk("lbu_data", got, 32'h0000_0080);

        // SH upper half, gnt after two waiting cycles
        run_access(4'd7, 32'h2002, 32'hABCD_1234, 5'd0, 1'b0, 2, 0, 32'd0, got, ns);
        chk("sh_stall_cycles", 32'(ns), 32'd4);

        // LW with no gnt: aborted after TO request cycles
        run_access(4'd5, 32'h40, 32'd0, 5'd10, 1'b1, 20, 0, 32'd0, got, ns);
        chk("to_stall_cycles", 32'(ns), 32'(1 + TO));
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("to_after_err", 32'(bus_err), 32'd0);
        chk("to_after_stall", 32'(stall), 32'd0);

        // reset while waiting for read data; late rvalid must be ignored
        @(negedge clk);
        drive(1'b1, 4'd5, 32'h80, 32'd0, 32'd0, 5'd9, 1'b1);
        @(negedge clk);
        bus_gnt = 1'b1;
        #1;
        chk("rst_mid_req", 32'(bus_req), 32'd1);
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        chk("rst_mid_wait_stall", 32'(stall), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1111_2222;
        #1;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_req_low", 32'(bus_req), 32'd0);
        chk("rst_mid_wbrw", 32'(wb_regwrite), 32'd0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        chk("rst_mid_late_wbrw", 32'(wb_regwrite), 32'd0);
        chk("rst_mid_late_stall", 32'(stall), 32'd0);
        run_access(4'd5, 32'h84, 32'd0, 5'd9, 1'b1, 1, 1, 32'h3333_4444, got, ns);
        chk("rst_recover_data", got, 32'h3333_4444);

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic        iv;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            iv = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) != 0) begin
                if (op == 4'd3 || op == 4'd4 || op == 4'd7) a[0] = 1'b0;
                if (op == 4'd5 || op == 4'd8) a[1:0] = 2'b00;
            end
            if (iv && op >= 4'd1 && op <= 4'd8 && !model_misaligned(op, a))
                run_access(op, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 5), $urandom_range(0, 4), $urandom, got, ns);
            else
                idle_cycle(iv, op, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
